// File: rtl/result_serializer.sv
// result_serializer: LSB-first parallel-to-serial output stage with a one-entry holding buffer.
// Define PARITY_EN to append an even-parity bit to every frame (frame length WIDTH+1).
module result_serializer #(
    parameter int WIDTH      = 32,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid_in,
    output logic             data_rdy_out,
    output logic             serial_out,
    output logic             frame_out,
    output logic             done_out,
    output logic             busy_out
);
    localparam int CW = $clog2(WIDTH);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, PARITY} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             last_bit;

    assign last_bit = cnt_q == CW'(WIDTH - 1);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        if (data_valid_in && !hold_full_q) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end
        case (state_q)
            IDLE: if (hold_full_q) begin
                shift_d     = hold_q;
                hold_full_d = 1'b0;
                cnt_d       = '0;
                state_d     = SHIFT;
            end
            SHIFT: begin
                shift_d = shift_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (last_bit) begin
                    cnt_d = '0;
                    gap_d = GW'(GAP_CYCLES - 1);
`ifdef PARITY_EN
                    state_d = PARITY;
`else
                    state_d = GAP;
`endif
                end
            end
            PARITY: state_d = GAP;
            GAP: begin
                if (gap_q == '0) state_d = IDLE;
                else gap_d = gap_q - GW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef PARITY_EN
    // Parity is captured when the word leaves the hold, since the shifter is consumed bit by bit.
    logic par_q;
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) par_q <= 1'b0;
        else if (state_q == IDLE && hold_full_q) par_q <= ^hold_q;
    end
    assign serial_out = (state_q == SHIFT) ? shift_q[0] : (state_q == PARITY) ? par_q : 1'b0;
    assign done_out   = state_q == PARITY;
`else
    assign serial_out = (state_q == SHIFT) ? shift_q[0] : 1'b0;
    assign done_out   = (state_q == SHIFT) && last_bit;
`endif

    assign frame_out    = (state_q == SHIFT) || (state_q == PARITY);
    assign data_rdy_out = !hold_full_q;
    assign busy_out     = (state_q != IDLE) || hold_full_q;
endmodule
